csa_stream_accumulator: RTL



---
 rtl/csa_stream_accumulator_pkg.sv | 35 +++
 rtl/csa_stream_accumulator_csa_row.sv | 32 +++
 rtl/csa_stream_accumulator.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/csa_stream_accumulator_pkg.sv
// Shared types and helpers for the carry-save stream accumulator.
package csa_stream_accumulator_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Widest operand/accumulator the extension helper can handle.
    localparam int EXT_MAX_W = 256;

    function automatic int calc_acc_w(input int width, input int guard);
        return width + guard;
    endfunction

    function automatic int calc_nchunk(input int acc_w, input int chunk);
        return acc_w / chunk;
    endfunction

    function automatic logic [EXT_MAX_W-1:0] extend_operand(
        input logic [EXT_MAX_W-1:0] data,
        input int                   width,
        input bit                   sign_en
    );
        logic [EXT_MAX_W-1:0] v;
        logic                 fill;
        fill = sign_en & data[width-1];
        for (int i = 0; i < EXT_MAX_W; i++) begin
            v[i] = (i < width) ? data[i] : fill;
        end
        return v;
    endfunction

endpackage

// File: rtl/csa_stream_accumulator_csa_row.sv
// Bit-level full adder cell and the W-bit 3:2 compressor row built from it.
module fullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_c;
    assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module csa_row #(
    parameter int W = 80
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);
    // Carry is returned unshifted; the caller aligns it one bit up.
    for (genvar g = 0; g < W; g++) begin : g_fa
        fullAdder u_fa (
            .i_a (i_a[g]),
            .i_b (i_b[g]),
            .i_c (i_c[g]),
            .o_s (o_sum[g]),
            .o_co(o_carry[g])
        );
    end
endmodule

// File: rtl/csa_stream_accumulator.sv
// Streaming carry-save accumulator with chunked carry-propagate resolve.
// Optional abort input enabled by CSA_STREAM_ACCUMULATOR_ABORT_EN.
module csa_stream_accumulator
    import csa_stream_accumulator_pkg::*;
#(
    parameter int  WIDTH  = 64,
    parameter int  GUARD  = 16,
    parameter int  CHUNK  = 16,
    parameter int  SIGNED = 0,
    localparam int ACC_W  = calc_acc_w(WIDTH, GUARD)
) (
    input  logic             clk,
    input  logic             reset,
`ifdef CSA_STREAM_ACCUMULATOR_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_overflow
);
    localparam int            NCHUNK    = calc_nchunk(ACC_W, CHUNK);
    localparam int            KW        = $clog2(NCHUNK + 1);
    localparam int            CW        = GUARD + 2;
    localparam logic [CW-1:0] OVF_LIMIT = CW'(1) << GUARD;
    localparam logic [CW-1:0] CNT_MAX   = OVF_LIMIT + CW'(1);
    localparam logic [KW-1:0] K_FINAL   = KW'(NCHUNK);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_s;
    logic [ACC_W-1:0] r_c;
    logic [ACC_W-1:0] r_res;
    logic [ACC_W-1:0] r_out_sum;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic             r_out_ovf;
    logic [KW-1:0]    r_k;
    logic             w_abort;
    logic             w_accept;
    logic [ACC_W-1:0] w_x;
    logic [ACC_W-1:0] w_row_s;
    logic [ACC_W-1:0] w_row_c;
    logic [KW-1:0]    w_kidx;
    logic [CHUNK-1:0] w_s_chunk;
    logic [CHUNK-1:0] w_c_chunk;
    logic [CHUNK:0]   w_chunk_sum;

`ifdef CSA_STREAM_ACCUMULATOR_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_x      = ACC_W'(extend_operand(EXT_MAX_W'(in_data), WIDTH, SIGNED != 0));
    assign w_accept = in_valid & in_ready;

    csa_row #(.W(ACC_W)) u_row (
        .i_a    (r_s),
        .i_b    (r_c),
        .i_c    (w_x),
        .o_sum  (w_row_s),
        .o_carry(w_row_c)
    );

    // Index is clamped so the finalize cycle (k == NCHUNK) never selects out of range.
    assign w_kidx      = (r_k < K_FINAL) ? r_k : KW'(0);
    assign w_s_chunk   = r_s[w_kidx*CHUNK +: CHUNK];
    assign w_c_chunk   = r_c[w_kidx*CHUNK +: CHUNK];
    assign w_chunk_sum = {1'b0, w_s_chunk} + {1'b0, w_c_chunk} + (CHUNK+1)'(r_carry);

    assign out_sum      = r_out_sum;
    assign out_overflow = r_out_ovf;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = ~w_abort;
                if (~w_abort && in_valid && in_last) begin
                    w_state_nxt = RESOLVE;
                end else begin
                    w_state_nxt = ACCUM;
                end
            end
            RESOLVE: begin
                if (w_abort) begin
                    w_state_nxt = ACCUM;
                end else if (r_k == K_FINAL) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RESOLVE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ACCUM;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    // Accumulate, chunked resolve, and output capture; the extra finalize cycle
    // copies the result into dedicated output registers held through DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s       <= '0;
            r_c       <= '0;
            r_count   <= '0;
            r_carry   <= 1'b0;
            r_k       <= '0;
            r_res     <= '0;
            r_out_sum <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_abort) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_count <= '0;
                        r_carry <= 1'b0;
                        r_k     <= '0;
                    end else if (w_accept) begin
                        r_s     <= w_row_s;
                        r_c     <= w_row_c << 1'b1;
                        r_count <= (r_count == CNT_MAX) ? r_count : r_count + CW'(1);
                        if (in_last) begin
                            r_carry <= 1'b0;
                            r_k     <= '0;
                        end
                    end
                end
                RESOLVE: begin
                    if (w_abort) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_count <= '0;
                        r_carry <= 1'b0;
                        r_k     <= '0;
                    end else if (r_k == K_FINAL) begin
                        r_out_sum <= r_res;
                        r_out_ovf <= (r_count > OVF_LIMIT);
                    end else begin
                        r_res[w_kidx*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
                        r_carry <= w_chunk_sum[CHUNK];
                        r_k     <= r_k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_s <= '0;
                end
            endcase
        end
    end

endmodule
